// File: rtl/fifo_pkt_pkg.sv
// Shared sizing for the async_fifo read-side packer (fifo_rd_packer, fifo_rd_acc).
package fifo_pkt_pkg;
  localparam int PKT_DATA_WIDTH = 4;
  localparam int PKT_PACK_NUM   = 2;
  localparam int PKT_OUT_WIDTH  = PKT_DATA_WIDTH * PKT_PACK_NUM;
  localparam int PKT_CNT_W      = $clog2(PKT_PACK_NUM + 1);

  // Fill counter must reach PACK_NUM itself, hence +1.
  function automatic int cnt_width(input int pack_num);
    return $clog2(pack_num + 1);
  endfunction
endpackage

// File: rtl/fifo_rd_acc.sv
// Slot-indexed accumulator: each captured FIFO word lands in slot cnt, then cnt increments.
// Clear zeroes every slot so a partial (flushed) word carries zeros in unfilled slots.
module fifo_rd_acc
  import fifo_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = PKT_DATA_WIDTH,
  parameter int PACK_NUM   = PKT_PACK_NUM
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_wr,
  input  logic                                i_clr,
  input  logic [DATA_WIDTH-1:0]               i_data,
  output logic [cnt_width(PACK_NUM)-1:0]      o_cnt,
  output logic [PACK_NUM-1:0][DATA_WIDTH-1:0] o_acc
);
  localparam int CNT_W = cnt_width(PACK_NUM);

  logic [CNT_W-1:0]                   r_cnt;
  logic [PACK_NUM-1:0][DATA_WIDTH-1:0] r_acc;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_wr) begin
      r_cnt <= r_cnt + 1'b1;
      for (int i = 0; i < PACK_NUM; i++)
        if (r_cnt == CNT_W'(i)) r_acc[i] <= i_data;
    end
  end

  assign o_cnt = r_cnt;
  assign o_acc = r_acc;
endmodule

// File: rtl/fifo_rd_packer.sv
// Pops async_fifo words, packs PACK_NUM of them into one valid/ready word.
// Optional PACKER_FLUSH_EN adds flush/out_cnt to emit a partial group.
module fifo_rd_packer
  import fifo_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = PKT_DATA_WIDTH,
  parameter int PACK_NUM   = PKT_PACK_NUM
) (
  input  logic                           rd_clk,
  input  logic                           rd_rst,
  input  logic                           fifo_empty,
  output logic                           fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]          fifo_rd_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH*PACK_NUM-1:0] out_data
`ifdef PACKER_FLUSH_EN
  ,
  input  logic                           flush,
  output logic [cnt_width(PACK_NUM)-1:0] out_cnt
`endif
);
  localparam int OUT_WIDTH = DATA_WIDTH * PACK_NUM;
  localparam int CNT_W     = cnt_width(PACK_NUM);

  logic                                r_pop_d1;
  logic                                r_out_valid;
  logic [OUT_WIDTH-1:0]                r_out_data;
  logic [CNT_W-1:0]                    w_cnt;
  logic [PACK_NUM-1:0][DATA_WIDTH-1:0] w_acc;
  logic [CNT_W:0]                      w_fill;
  logic                                w_out_free;
  logic                                w_xfer;
  logic                                w_flush_go;

  fifo_rd_acc #(.DATA_WIDTH(DATA_WIDTH), .PACK_NUM(PACK_NUM)) u_acc (
    .clk    (rd_clk),
    .rst    (rd_rst),
    .i_wr   (r_pop_d1),
    .i_clr  (w_xfer || w_flush_go),
    .i_data (fifo_rd_data),
    .o_cnt  (w_cnt),
    .o_acc  (w_acc)
  );

  // Words already in the accumulator plus the one in flight must stay below PACK_NUM.
  assign w_fill     = {1'b0, w_cnt} + (CNT_W+1)'(r_pop_d1);
  assign w_out_free = !r_out_valid || out_ready;
  assign w_xfer     = (w_cnt == CNT_W'(PACK_NUM)) && w_out_free;

`ifdef PACKER_FLUSH_EN
  assign w_flush_go = flush && (w_cnt != '0) && !r_pop_d1 && w_out_free;
`else
  assign w_flush_go = 1'b0;
`endif

  assign fifo_rd_en = !fifo_empty && !rd_rst && !w_flush_go &&
                      (w_fill < (CNT_W+1)'(PACK_NUM));

  always_ff @(posedge rd_clk) begin
    if (rd_rst) r_pop_d1 <= 1'b0;
    else        r_pop_d1 <= fifo_rd_en;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_xfer || w_flush_go) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_acc;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef PACKER_FLUSH_EN
  logic [CNT_W-1:0] r_out_cnt;

  always_ff @(posedge rd_clk) begin
    if (rd_rst)          r_out_cnt <= '0;
    else if (w_xfer)     r_out_cnt <= CNT_W'(PACK_NUM);
    else if (w_flush_go) r_out_cnt <= w_cnt;
  end

  assign out_cnt = r_out_cnt;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer with a queue-based async_fifo read-port model.
// Exercises flush/out_cnt when PACKER_FLUSH_EN is defined.
module tb_fifo_rd_packer;
  localparam int DW = 4;
  localparam int PN = 2;
  localparam int OW = DW * PN;
  localparam int CW = $clog2(PN + 1);

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          out_ready = 1'b0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_en;
  logic          out_valid;
  logic [OW-1:0] out_data;
`ifdef PACKER_FLUSH_EN
  logic          flush = 1'b0;
  logic [CW-1:0] out_cnt;
`endif

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_NUM(PN)) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
`ifdef PACKER_FLUSH_EN
    ,
    .flush        (flush),
    .out_cnt      (out_cnt)
`endif
  );

  always #12 rd_clk = ~rd_clk;

  typedef struct {
    logic [OW-1:0] data;
    int            cnt;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] fq[$];   // words sitting in the FIFO
  logic [DW-1:0] grp[$];  // words popped but not yet emitted as a packed word
  int            n_tests = 0;
  int            n_fail = 0;
  int            beats = 0;
  bit            pop_pend = 1'b0;
  bit            prev_stall = 1'b0;
  logic [OW-1:0] prev_data = '0;
  exp_t          mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Packed word = popped words concatenated, first word in the low slot, rest zero.
  function automatic exp_t pack_grp();
    exp_t e;
    e.data = '0;
    for (int i = 0; i < grp.size(); i++) e.data[i*DW +: DW] = grp[i];
    e.cnt = grp.size();
    return e;
  endfunction

  // Monitor: FIFO read-port sampling and output-side scoreboard.
  always @(negedge rd_clk) begin
    pop_pend = fifo_rd_en;
    if (fifo_rd_en) check("no_pop_while_empty", {31'd0, fifo_empty}, 32'd0);
    if (rd_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", {31'd0, out_valid}, 32'd1);
        check("stall_data_stable", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h, required no beat", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", 32'(out_data), 32'(mon_e.data));
`ifdef PACKER_FLUSH_EN
          check("beat_cnt", 32'(out_cnt), 32'(mon_e.cnt));
`endif
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // One rd_clk cycle; the FIFO model delivers popped data one cycle after rd_en.
  task automatic cyc();
    @(posedge rd_clk);
    #1;
    if (pop_pend) begin
      pop_pend = 1'b0;
      if (fq.size() > 0) begin
        fifo_rd_data = fq.pop_front();
        grp.push_back(fifo_rd_data);
        if (grp.size() == PN) begin
          exp_q.push_back(pack_grp());
          grp.delete();
        end
      end
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    rd_rst = 1'b1;
    fq.delete();
    grp.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    cyc();
    cyc();
    rd_rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fq.size() != 0 || pop_pend) && n < budget) begin
      cyc();
      n++;
    end
    if (n >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending words, required 0", name, exp_q.size());
    end
    repeat (4) cyc();
  endtask

  int b0;
  int sent;

  initial begin
    // Test 1 + reset state: data waiting in the FIFO must not be popped under reset.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(DW'(i + 13));
    cyc();
    cyc();
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
`ifdef PACKER_FLUSH_EN
    check("rst_out_cnt", 32'(out_cnt), 32'd0);
`endif
    b0 = beats;
    rd_rst = 1'b0;
    drain("t1", 100);
    check("t1_beats", beats - b0, 32'd5);
    check("t1_empty", {31'd0, fifo_empty}, 32'd1);

    // Test 2: backpressure with both accumulator and output register full.
    do_reset();
    out_ready = 1'b0;
    b0 = beats;
    for (int i = 0; i < 10; i++) push(DW'(i + 13));
    repeat (20) cyc();
    check("t2_bp_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("t2_bp_fifo_left", fq.size(), 32'd6);
    check("t2_bp_valid", {31'd0, out_valid}, 32'd1);
    check("t2_bp_data", 32'(out_data), 32'hED);
    out_ready = 1'b1;
    drain("t2", 100);
    check("t2_beats", beats - b0, 32'd5);

    // Test 3: odd word count leaves one word parked in the accumulator.
    do_reset();
    out_ready = 1'b1;
    b0 = beats;
    push(4'hA);
    push(4'hB);
    push(4'hC);
    drain("t3", 50);
    check("t3_beats", beats - b0, 32'd1);
    check("t3_idle_valid", {31'd0, out_valid}, 32'd0);

`ifdef PACKER_FLUSH_EN
    // Test 5: flush the parked word, then flush an empty accumulator.
    b0 = beats;
    exp_q.push_back(pack_grp());
    grp.delete();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drain("t5", 20);
    check("t5_flush_beats", beats - b0, 32'd1);
    b0 = beats;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (4) cyc();
    check("t5_empty_flush_beats", beats - b0, 32'd0);
`endif

    // Test 4: reset lands between a pop and its data capture.
    do_reset();
    out_ready = 1'b1;
    push(4'h5);
    for (int i = 0; i < 10 && grp.size() == 0; i++) cyc();
    check("t4_popped", grp.size(), 32'd1);
    rd_rst = 1'b1;
    grp.delete();
    exp_q.delete();
    cyc();
    rd_rst = 1'b0;
    check("t4_post_rst_valid", {31'd0, out_valid}, 32'd0);
    b0 = beats;
    push(4'h1);
    push(4'h2);
    drain("t4", 50);
    check("t4_beats", beats - b0, 32'd1);

    // Test 6: continuous random writes, out_ready toggling then random.
    do_reset();
    b0 = beats;
    sent = 0;
    while (sent < 40) begin
      if ($urandom_range(0, 3) != 0) begin
        push(DW'($urandom_range(0, 15)));
        sent++;
      end
      out_ready = ~out_ready;
      cyc();
    end
    while (sent < 80) begin
      if ($urandom_range(0, 1) != 0) begin
        push(DW'($urandom_range(0, 15)));
        sent++;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    out_ready = 1'b1;
    drain("t6", 300);
    check("t6_beats", beats - b0, 32'd40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
